split_access_seq: RTL and testbench
===================================

Name: split_access_seq

Overview:
- Sequencing controller that sits in front of the M-stage input aligner and D-cache port.
- Accepts one memory request at a time, waits for translation/protection status, then issues one or two 16-byte line accesses (two when the access crosses a line, i.e. need_p1).
- Merges the two line responses into one right-aligned result and reports faults.
- Owns the half-select to the aligner/cache pair and the retry counter for TLB misses.

Parameters:
- LINE_W, 128, line and data width in bits (16 bytes).
- ADDR_W, 32, virtual address width.
- TLB_RETRY, 4, number of cycles a TLB miss is re-sampled before it is reported as a fault (1..15).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active low.
- req_valid  in  1  new request.
- req_ready  out  1  accepted when req_valid & req_ready.
- req_addr  in  ADDR_W  virtual byte address.
- req_size  in  2  0=1B, 1=2B, 2=4B, 3=8B.
- req_w  in  1  write request.
- need_p1  in  1  aligner says the access spans two lines; sampled in CHK.
- tlb_hit  in  1  both halves translated.
- tlb_miss  in  1  either half missed.
- prot_exc  in  1  protection violation.
- pcd  in  1  page cache-disable; forwarded in the response.
- c_valid  out  1  cache access request.
- c_half  out  1  0 selects aligner half 0, 1 selects half 1.
- c_ready  in  1  cache accepts when c_valid & c_ready.
- c_rvalid  in  1  line response valid (one per accepted access, in order).
- c_rdata  in  LINE_W  line data.
- resp_valid  out  1  one-cycle result strobe.
- resp_data  out  LINE_W  merged, right-aligned data.
- resp_fault  out  2  bit0 TLB miss, bit1 protection.
- resp_pcd  out  1  pcd captured in CHK.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst=0 at a clk edge) takes priority over everything, including mid-operation:
  - state = IDLE;
  - all outputs 0, except req_ready = 1;
  - internal registers (addr, size, split, retry count, line buffers) cleared;
  - any outstanding cache response arriving after reset is ignored.
- FSM states: IDLE, CHK, ISS0, WT0, ISS1, WT1, DONE, FLT.
- IDLE:
  - req_ready = 1.
  - On accept: latch req_addr, req_size and req_w; retry = 0; go to CHK.
- CHK:
  - Latch split = need_p1 and pcd.
  - If prot_exc: go to FLT with fault bit1. prot_exc has priority over tlb_miss when both are set.
  - Else if tlb_miss: if retry == TLB_RETRY-1, go to FLT with bit0; otherwise retry++ and stay in CHK.
  - Else if tlb_hit: go to ISS0.
  - Else: stay in CHK without incrementing retry.
- ISS0: c_valid = 1, c_half = 0. Hold both until c_ready, then go to WT0.
- WT0:
  - On c_rvalid: line0 <= c_rdata.
  - Then go to ISS1 if split, else DONE.
  - If c_rvalid coincides with the c_ready handshake in ISS0, the response is captured in that same cycle and WT0 is skipped.
- ISS1 / WT1: same as ISS0 / WT0 with c_half = 1, capturing line1; then go to DONE.
- DONE:
  - resp_valid = 1 for exactly one cycle; resp_fault = 0.
  - resp_data = low LINE_W bits of ({line1, line0} >> (8*addr[3:0])), with line1 = 0 when the access is not split.
  - Bytes above the request size are zeroed: keep 1/2/4/8 low bytes for size 0/1/2/3.
  - Go to IDLE. req_ready rises the following cycle; there is no back-to-back accept in DONE.
- FLT: resp_valid = 1 for one cycle, resp_data = 0, resp_fault per the cause; go to IDLE. No cache access is issued for a faulting request.
- Latency with no stalls and no misses, measured from the accept edge to resp_valid:
  - single line: 4 cycles (CHK, ISS0, WT0, DONE);
  - split: 6 cycles.
- Ordering and throughput:
  - Exactly one outstanding cache access at a time.
  - c_half=1 is never issued before line0 is captured.
  - A split request is never issued when need_p1 was 0 at CHK.
- Boundary cases:
  - addr[3:0] = 0xF with size 3 → split; bytes 1..7 of the result come from line1[55:0].
  - addr[3:0] + bytes = 16 exactly → not split; the aligner drives need_p1 = 0 and the sequencer trusts it.
  - Address wrap-around at 0xFFFF_FFF0 is handled by the aligner; the sequencer only uses addr[3:0].
- req_w does not change sequencing; it is forwarded to the aligner externally and only latched for debug visibility.

Decomposition:
- Shared package m_cache_pkg:
  - state encoding (3-bit enum constants);
  - size-to-byte-count constants;
  - fault bit positions (FLT_TLB = 0, FLT_PROT = 1).
- One sub-module: split_merge, the combinational 256→128 byte right-shift plus size mask, built from a 4-stage mux2 shifter over 32 byte lanes.

Test Plan:
- Single-line read, addr=0x0000_1004, size=2, tlb_hit=1, c_ready=1, line0=0x…_DDCCBBAA_00000000 → one c_valid with c_half=0; resp_data=0xDDCCBBAA; resp_valid at accept+4; resp_fault=0.
- Split read, addr=0x0000_100E, size=3, need_p1=1, line0 bytes E,F=0x11,0x22, line1 bytes 0..5=0x33..0x88 → two accesses with c_half 0 then 1; resp_data=0x8877665544332211; latency 6.
- TLB miss persistent: tlb_miss=1 for 10 cycles, TLB_RETRY=4 → no c_valid; resp_fault=2'b01 four cycles after entering CHK; then returns to IDLE.
- TLB miss clears at retry 2 then hit → normal completion; resp_fault=0.
- prot_exc=1 and tlb_miss=1 together → resp_fault=2'b10; no cache access.
- c_ready held low 5 cycles in ISS1, then rst=0 asserted during WT1 → next cycle busy=0, req_ready=1, no resp_valid; a late c_rvalid is ignored.

Source files
------------

// File: rtl/split_access_seq_pkg.sv
// Shared definitions for the split-access sequencer.
//   state_e        : FSM state encoding (3-bit)
//   FLT_TLB/PROT   : bit positions inside the 2-bit fault code
//   size_bytes()   : request size code (0..3) to byte count (1/2/4/8)
package split_access_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CHK  = 3'd1,
        ST_ISS0 = 3'd2,
        ST_WT0  = 3'd3,
        ST_ISS1 = 3'd4,
        ST_WT1  = 3'd5,
        ST_DONE = 3'd6,
        ST_FLT  = 3'd7
    } state_e;

    localparam int FLT_TLB  = 0;
    localparam int FLT_PROT = 1;

    localparam logic [4:0] BYTES_SZ0 = 5'd1;
    localparam logic [4:0] BYTES_SZ1 = 5'd2;
    localparam logic [4:0] BYTES_SZ2 = 5'd4;
    localparam logic [4:0] BYTES_SZ3 = 5'd8;

    function automatic logic [4:0] size_bytes(input logic [1:0] size);
        case (size)
            2'd0:    return BYTES_SZ0;
            2'd1:    return BYTES_SZ1;
            2'd2:    return BYTES_SZ2;
            default: return BYTES_SZ3;
        endcase
    endfunction

endpackage

// File: rtl/split_access_seq_if.sv
// Bus bundle between the requester/TLB/cache environment and the sequencer.
//   request : req_valid/req_ready/req_addr/req_size/req_w
//   status  : need_p1, tlb_hit, tlb_miss, prot_exc, pcd
//   cache   : c_valid/c_half/c_ready, c_rvalid/c_rdata
//   result  : resp_valid/resp_data/resp_fault/resp_pcd, busy
//   debug   : dbg_addr/dbg_w (latched request address and write flag)
// Modport slave is the sequencer, master is the surrounding environment.
interface split_access_seq_if #(
    parameter int LINE_W = 128,
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic              req_w;
    logic              need_p1;
    logic              tlb_hit;
    logic              tlb_miss;
    logic              prot_exc;
    logic              pcd;
    logic              c_valid;
    logic              c_half;
    logic              c_ready;
    logic              c_rvalid;
    logic [LINE_W-1:0] c_rdata;
    logic              resp_valid;
    logic [LINE_W-1:0] resp_data;
    logic [1:0]        resp_fault;
    logic              resp_pcd;
    logic              busy;
    logic [ADDR_W-1:0] dbg_addr;
    logic              dbg_w;

    modport slave (
        input  req_valid, req_addr, req_size, req_w, need_p1, tlb_hit, tlb_miss,
               prot_exc, pcd, c_ready, c_rvalid, c_rdata,
        output req_ready, c_valid, c_half, resp_valid, resp_data, resp_fault,
               resp_pcd, busy, dbg_addr, dbg_w
    );

    modport master (
        output req_valid, req_addr, req_size, req_w, need_p1, tlb_hit, tlb_miss,
               prot_exc, pcd, c_ready, c_rvalid, c_rdata,
        input  req_ready, c_valid, c_half, resp_valid, resp_data, resp_fault,
               resp_pcd, busy, dbg_addr, dbg_w
    );
endinterface

// File: rtl/split_access_seq_merge.sv
// Combinational merge of two 16-byte lines into one right-aligned result.
//   pair_i  : {line1[LINE_W-9:0], line0}; the top byte of line1 can never
//             reach the result because the byte offset is at most 15
//   shift_i : byte offset addr[3:0]
//   size_i  : size code, bytes above 1/2/4/8 are zeroed
//   data_o  : merged result
// The shifter is four mux2 stages (8, 4, 2, 1 bytes); each stage keeps only
// the lanes that later stages can still move into the output window.
module split_access_seq_merge
    import split_access_seq_pkg::*;
#(
    parameter int LINE_W = 128
) (
    input  logic [LINE_W+119:0] pair_i,
    input  logic [3:0]          shift_i,
    input  logic [1:0]          size_i,
    output logic [LINE_W-1:0]   data_o
);
    localparam int W1 = LINE_W + 56;
    localparam int W2 = LINE_W + 24;
    localparam int W3 = LINE_W + 8;

    logic [W1-1:0]     s1;
    logic [W2-1:0]     s2;
    logic [W3-1:0]     s3;
    logic [LINE_W-1:0] s4;
    logic [4:0]        nbytes;

    assign s1 = shift_i[3] ? pair_i[LINE_W+119:64] : pair_i[W1-1:0];
    assign s2 = shift_i[2] ? s1[W1-1:32] : s1[W2-1:0];
    assign s3 = shift_i[1] ? s2[W2-1:16] : s2[W3-1:0];
    assign s4 = shift_i[0] ? s3[W3-1:8]  : s3[LINE_W-1:0];

    assign nbytes = size_bytes(size_i);

    genvar gi;
    generate
        for (gi = 0; gi < LINE_W / 8; gi++) begin : g_mask
            assign data_o[gi*8 +: 8] = (5'(gi) < nbytes) ? s4[gi*8 +: 8] : 8'h00;
        end
    endgenerate
endmodule

// File: rtl/split_access_seq.sv
// Sequencer in front of the M-stage aligner and D-cache port. Accepts one
// request, waits for TLB/protection status, issues one or two line accesses
// (half 0, then half 1 when the access spans two lines), and returns a
// merged right-aligned result or a fault code.
//   clk, rst : clock, synchronous active-low reset
//   bus      : request, status, cache and result signals (slave modport)
module split_access_seq
    import split_access_seq_pkg::*;
#(
    parameter int LINE_W    = 128,
    parameter int ADDR_W    = 32,
    parameter int TLB_RETRY = 4
) (
    input  logic              clk,
    input  logic              rst,
    split_access_seq_if.slave bus
);
    localparam logic [3:0] RETRY_LAST = 4'(TLB_RETRY - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              w_q, w_d;
    logic              split_q, split_d;
    logic              pcd_q, pcd_d;
    logic [3:0]        retry_q, retry_d;
    logic [1:0]        fault_q, fault_d;
    logic [LINE_W-1:0] line0_q, line0_d;
    logic [LINE_W-9:0] line1_q, line1_d;
    logic              req_ready, c_valid, c_half, resp_valid;
    logic [LINE_W-1:0] merged;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            w_q     <= 1'b0;
            split_q <= 1'b0;
            pcd_q   <= 1'b0;
            retry_q <= '0;
            fault_q <= '0;
            line0_q <= '0;
            line1_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            w_q     <= w_d;
            split_q <= split_d;
            pcd_q   <= pcd_d;
            retry_q <= retry_d;
            fault_q <= fault_d;
            line0_q <= line0_d;
            line1_q <= line1_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        size_d     = size_q;
        w_d        = w_q;
        split_d    = split_q;
        pcd_d      = pcd_q;
        retry_d    = retry_q;
        fault_d    = fault_q;
        line0_d    = line0_q;
        line1_d    = line1_q;
        req_ready  = 1'b0;
        c_valid    = 1'b0;
        c_half     = 1'b0;
        resp_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid) begin
                    addr_d  = bus.req_addr;
                    size_d  = bus.req_size;
                    w_d     = bus.req_w;
                    retry_d = '0;
                    fault_d = '0;
                    // line1 must read as zero for a non-split access
                    line0_d = '0;
                    line1_d = '0;
                    state_d = ST_CHK;
                end
            end
            ST_CHK: begin
                split_d = bus.need_p1;
                pcd_d   = bus.pcd;
                if (bus.prot_exc) begin
                    fault_d[FLT_PROT] = 1'b1;
                    state_d = ST_FLT;
                end else if (bus.tlb_miss) begin
                    if (retry_q == RETRY_LAST) begin
                        fault_d[FLT_TLB] = 1'b1;
                        state_d = ST_FLT;
                    end else begin
                        retry_d = retry_q + 4'd1;
                    end
                end else if (bus.tlb_hit) begin
                    state_d = ST_ISS0;
                end
            end
            ST_ISS0: begin
                c_valid = 1'b1;
                if (bus.c_ready) begin
                    // a same-cycle response skips the wait state
                    if (bus.c_rvalid) begin
                        line0_d = bus.c_rdata;
                        state_d = split_q ? ST_ISS1 : ST_DONE;
                    end else begin
                        state_d = ST_WT0;
                    end
                end
            end
            ST_WT0: begin
                if (bus.c_rvalid) begin
                    line0_d = bus.c_rdata;
                    state_d = split_q ? ST_ISS1 : ST_DONE;
                end
            end
            ST_ISS1: begin
                c_valid = 1'b1;
                c_half  = 1'b1;
                if (bus.c_ready) begin
                    if (bus.c_rvalid) begin
                        line1_d = bus.c_rdata[LINE_W-9:0];
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WT1;
                    end
                end
            end
            ST_WT1: begin
                if (bus.c_rvalid) begin
                    line1_d = bus.c_rdata[LINE_W-9:0];
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                resp_valid = 1'b1;
                state_d    = ST_IDLE;
            end
            ST_FLT: begin
                resp_valid = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    split_access_seq_merge #(.LINE_W(LINE_W)) u_merge (
        .pair_i  ({line1_q, line0_q}),
        .shift_i (addr_q[3:0]),
        .size_i  (size_q),
        .data_o  (merged)
    );

    assign bus.req_ready  = req_ready;
    assign bus.c_valid    = c_valid;
    assign bus.c_half     = c_half;
    assign bus.resp_valid = resp_valid;
    assign bus.resp_data  = (state_q == ST_DONE) ? merged : '0;
    assign bus.resp_fault = (state_q == ST_FLT) ? fault_q : 2'b00;
    assign bus.resp_pcd   = resp_valid & pcd_q;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.dbg_addr   = addr_q;
    assign bus.dbg_w      = w_q;
endmodule

// File: tb/tb_split_access_seq.sv
module tb_split_access_seq;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    split_access_seq_if #(.LINE_W(128), .ADDR_W(32)) bus ();

    split_access_seq #(.LINE_W(128), .ADDR_W(32), .TLB_RETRY(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int passed = 0;
    int total  = 0;

    // monitor state (written only by the monitor process)
    int           cyc = 0;
    int           resp_cnt = 0;
    int           resp_cyc = 0;
    int           cv_cnt = 0;
    int           hs_n = 0;
    logic [127:0] r_data;
    logic [1:0]   r_fault;
    logic         r_pcd;
    logic         hs_half [16];

    // cache model
    logic [127:0] line_mem [2];
    logic         cache_en = 1'b1;
    logic         m_hs, m_half;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bus.resp_valid) begin
            resp_cnt = resp_cnt + 1;
            resp_cyc = cyc;
            r_data   = bus.resp_data;
            r_fault  = bus.resp_fault;
            r_pcd    = bus.resp_pcd;
        end
        if (bus.c_valid) cv_cnt = cv_cnt + 1;
        if (bus.c_valid && bus.c_ready) begin
            if (hs_n < 16) hs_half[hs_n] = bus.c_half;
            hs_n = hs_n + 1;
        end
    end

    // responds one cycle after each accepted access
    always @(negedge clk) begin
        m_hs   = bus.c_valid && bus.c_ready;
        m_half = bus.c_half;
        @(posedge clk);
        #1;
        if (cache_en) begin
            bus.c_rvalid = m_hs;
            bus.c_rdata  = m_hs ? line_mem[m_half] : 128'h0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic start_req(input logic [31:0] a, input logic [1:0] sz, output int acc_cyc);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_size  = sz;
        bus.req_w     = 1'b0;
        @(posedge clk);
        acc_cyc = cyc;
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_resp(input int base, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            if (resp_cnt > base) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic set_status(input logic hit, input logic miss, input logic prot,
                              input logic p1, input logic pc);
        bus.tlb_hit  = hit;
        bus.tlb_miss = miss;
        bus.prot_exc = prot;
        bus.need_p1  = p1;
        bus.pcd      = pc;
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b1; bus.req_addr = 32'h0; bus.req_size = 2'd0; bus.req_w = 1'b0;
        set_status(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.c_ready = 1'b1; bus.c_rvalid = 1'b0; bus.c_rdata = 128'h0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (bus.req_ready !== 1'b1) $display("FAIL reset_req_ready got=%0h exp=1", bus.req_ready); else passed++;
        total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%0h exp=0", bus.busy); else passed++;
        total++; if (bus.c_valid !== 1'b0) $display("FAIL reset_c_valid got=%0h exp=0", bus.c_valid); else passed++;
        total++; if (bus.resp_valid !== 1'b0) $display("FAIL reset_resp_valid got=%0h exp=0", bus.resp_valid); else passed++;
        total++; if (bus.resp_data !== 128'h0 || bus.resp_fault !== 2'b00) $display("FAIL reset_resp got=%h/%b exp=0/00", bus.resp_data, bus.resp_fault); else passed++;
        bus.req_valid = 1'b0;
        rst = 1'b1;
        $display("txn reset released");
    endtask

    task automatic test_single();
        int acc, base, hsb, cvb; logic ok;
        line_mem[0] = 128'h0123_4567_89AB_CDEF_DDCC_BBAA_0000_0000;
        line_mem[1] = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
        set_status(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        base = resp_cnt; hsb = hs_n; cvb = cv_cnt;
        start_req(32'h0000_1004, 2'd2, acc);
        wait_resp(base, ok);
        total++; if (!ok) $display("FAIL single_timeout got=none exp=resp_valid"); else passed++;
        total++; if (r_data !== 128'hDDCC_BBAA) $display("FAIL single_data got=%h exp=ddccbbaa", r_data); else passed++;
        total++; if (r_fault !== 2'b00) $display("FAIL single_fault got=%b exp=00", r_fault); else passed++;
        total++; if (resp_cyc - acc !== 4) $display("FAIL single_latency got=%0d exp=4", resp_cyc - acc); else passed++;
        total++; if (hs_n - hsb !== 1 || cv_cnt - cvb !== 1 || hs_half[hsb] !== 1'b0) $display("FAIL single_access got=%0d/%0d/%0b exp=1/1/0", hs_n - hsb, cv_cnt - cvb, hs_half[hsb]); else passed++;
        @(negedge clk);
        total++; if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0) $display("FAIL single_idle got=%0b%0b exp=10", bus.req_ready, bus.busy); else passed++;
        $display("txn single addr=00001004 size=2 data=%h fault=%b lat=%0d", r_data, r_fault, resp_cyc - acc);
    endtask

    task automatic test_split();
        int acc, base, hsb; logic ok;
        line_mem[0] = 128'h2211_5555_5555_5555_5555_5555_5555_5555;
        line_mem[1] = 128'h9999_9999_9999_9999_9999_8877_6655_4433;
        set_status(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        base = resp_cnt; hsb = hs_n;
        start_req(32'h0000_100E, 2'd3, acc);
        wait_resp(base, ok);
        total++; if (!ok) $display("FAIL split_timeout got=none exp=resp_valid"); else passed++;
        total++; if (r_data !== 128'h8877_6655_4433_2211) $display("FAIL split_data got=%h exp=8877665544332211", r_data); else passed++;
        total++; if (resp_cyc - acc !== 6) $display("FAIL split_latency got=%0d exp=6", resp_cyc - acc); else passed++;
        total++; if (hs_n - hsb !== 2 || hs_half[hsb] !== 1'b0 || hs_half[hsb+1] !== 1'b1) $display("FAIL split_halves got=%0d/%0b%0b exp=2/01", hs_n - hsb, hs_half[hsb], hs_half[hsb+1]); else passed++;
        total++; if (r_pcd !== 1'b1 || r_fault !== 2'b00) $display("FAIL split_pcd_fault got=%0b/%b exp=1/00", r_pcd, r_fault); else passed++;
        $display("txn split addr=0000100e size=3 data=%h pcd=%0b lat=%0d", r_data, r_pcd, resp_cyc - acc);
    endtask

    task automatic test_boundary();
        int acc, base, hsb; logic ok;
        line_mem[0] = 128'hA1EE_EEEE_EEEE_EEEE_EEEE_EEEE_EEEE_EEEE;
        line_mem[1] = 128'h7777_7777_7777_7777_77B6_B5B4_B3B2_B1B0;
        set_status(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        base = resp_cnt; hsb = hs_n;
        start_req(32'hFFFF_FFFF, 2'd3, acc);
        wait_resp(base, ok);
        total++; if (!ok || r_data !== 128'hB6B5_B4B3_B2B1_B0A1) $display("FAIL bound_f_data got=%h exp=b6b5b4b3b2b1b0a1", r_data); else passed++;
        total++; if (hs_n - hsb !== 2) $display("FAIL bound_f_accesses got=%0d exp=2", hs_n - hsb); else passed++;
        $display("txn boundary addr=ffffffff size=3 data=%h", r_data);
        line_mem[0] = 128'hF4F3_F2F1_9999_9999_9999_9999_9999_9999;
        set_status(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        base = resp_cnt; hsb = hs_n;
        start_req(32'h0000_200C, 2'd2, acc);
        wait_resp(base, ok);
        total++; if (!ok || r_data !== 128'hF4F3_F2F1) $display("FAIL bound_c_data got=%h exp=f4f3f2f1", r_data); else passed++;
        total++; if (hs_n - hsb !== 1 || resp_cyc - acc !== 4) $display("FAIL bound_c_single got=%0d/%0d exp=1/4", hs_n - hsb, resp_cyc - acc); else passed++;
        $display("txn boundary addr=0000200c size=2 data=%h", r_data);
    endtask

    task automatic test_tlb_persistent();
        int acc, base, cvb; logic ok;
        set_status(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        base = resp_cnt; cvb = cv_cnt;
        start_req(32'h0000_3000, 2'd2, acc);
        wait_resp(base, ok);
        total++; if (!ok || r_fault !== 2'b01) $display("FAIL tlb_fault got=%b exp=01", r_fault); else passed++;
        total++; if (resp_cyc - acc !== 5) $display("FAIL tlb_latency got=%0d exp=5", resp_cyc - acc); else passed++;
        total++; if (cv_cnt !== cvb || r_data !== 128'h0) $display("FAIL tlb_no_access got=%0d/%h exp=0/0", cv_cnt - cvb, r_data); else passed++;
        @(negedge clk);
        total++; if (bus.busy !== 1'b0) $display("FAIL tlb_idle got=%0b exp=0", bus.busy); else passed++;
        set_status(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("txn tlb_miss addr=00003000 fault=%b lat=%0d", r_fault, resp_cyc - acc);
    endtask

    task automatic test_tlb_retry_clear();
        int acc, base; logic ok;
        line_mem[0] = 128'h0000_0000_00FF_A55A_0000_0000_0000_0000;
        set_status(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        base = resp_cnt;
        start_req(32'h0000_3008, 2'd1, acc);
        @(posedge clk);
        @(posedge clk);
        #1;
        set_status(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_resp(base, ok);
        total++; if (!ok || r_fault !== 2'b00) $display("FAIL retry_fault got=%b exp=00", r_fault); else passed++;
        total++; if (r_data !== 128'hA55A) $display("FAIL retry_data got=%h exp=a55a", r_data); else passed++;
        total++; if (resp_cyc - acc !== 6) $display("FAIL retry_latency got=%0d exp=6", resp_cyc - acc); else passed++;
        $display("txn tlb_retry addr=00003008 size=1 data=%h lat=%0d", r_data, resp_cyc - acc);
    endtask

    task automatic test_prot();
        int acc, base, cvb; logic ok;
        set_status(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        base = resp_cnt; cvb = cv_cnt;
        start_req(32'h0000_4000, 2'd0, acc);
        wait_resp(base, ok);
        total++; if (!ok || r_fault !== 2'b10) $display("FAIL prot_fault got=%b exp=10", r_fault); else passed++;
        total++; if (resp_cyc - acc !== 2 || cv_cnt !== cvb) $display("FAIL prot_path got=%0d/%0d exp=2/0", resp_cyc - acc, cv_cnt - cvb); else passed++;
        set_status(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("txn prot addr=00004000 fault=%b", r_fault);
    endtask

    task automatic test_reset_mid();
        int acc, base, hsb;
        line_mem[0] = 128'h1111_1111_1111_1111_1111_1111_1111_1111;
        line_mem[1] = 128'h2222_2222_2222_2222_2222_2222_2222_2222;
        set_status(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        bus.c_ready = 1'b1;
        base = resp_cnt; hsb = hs_n;
        start_req(32'h0000_5008, 2'd3, acc);
        @(posedge clk);
        @(posedge clk);
        #2;
        bus.c_ready = 1'b0;
        @(posedge clk);
        #2;
        cache_en = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        total++; if (bus.c_valid !== 1'b1 || bus.c_half !== 1'b1) $display("FAIL stall_iss1 got=%0b%0b exp=11", bus.c_valid, bus.c_half); else passed++;
        total++; if (hs_n - hsb !== 1) $display("FAIL stall_accesses got=%0d exp=1", hs_n - hsb); else passed++;
        bus.c_ready = 1'b1;
        @(posedge clk);
        #2;
        bus.c_ready = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        bus.c_rvalid = 1'b1;
        bus.c_rdata  = {4{32'hFFFF_FFFF}};
        @(negedge clk);
        total++; if (bus.busy !== 1'b0 || bus.req_ready !== 1'b1) $display("FAIL midrst_idle got=%0b%0b exp=01", bus.busy, bus.req_ready); else passed++;
        total++; if (bus.resp_valid !== 1'b0 || bus.c_valid !== 1'b0) $display("FAIL midrst_outputs got=%0b%0b exp=00", bus.resp_valid, bus.c_valid); else passed++;
        @(posedge clk);
        #2;
        bus.c_rvalid = 1'b0;
        bus.c_rdata  = 128'h0;
        repeat (3) @(negedge clk);
        total++; if (resp_cnt !== base || bus.busy !== 1'b0) $display("FAIL midrst_late_rvalid got=%0d/%0b exp=0/0", resp_cnt - base, bus.busy); else passed++;
        cache_en = 1'b1;
        bus.c_ready = 1'b1;
        set_status(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("txn reset_mid addr=00005008 responses=%0d", resp_cnt - base);
    endtask

    task automatic test_after_reset();
        int acc, base; logic ok;
        line_mem[0] = 128'h0807_0605_0403_0201_1234_5678_9ABC_DEF0;
        set_status(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        base = resp_cnt;
        start_req(32'h0000_6008, 2'd3, acc);
        wait_resp(base, ok);
        total++; if (!ok || r_data !== 128'h0807_0605_0403_0201) $display("FAIL post_reset_data got=%h exp=0807060504030201", r_data); else passed++;
        $display("txn post_reset addr=00006008 size=3 data=%h", r_data);
    endtask

    initial begin
        test_reset();
        test_single();
        test_split();
        test_boundary();
        test_tlb_persistent();
        test_tlb_retry_clear();
        test_prot();
        test_reset_mid();
        test_after_reset();
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
